// File: rtl/genhier_pack_seq.sv
// Packs the enabled fields of a 128-bit word (alternating 3-bit/4-bit slots) densely, LSB-first.
// Latency: accept at edge T, result valid after edge T+NFIELDS; one slot per cycle regardless of mask.
// Backpressure: result is held stable in DONE until out_ready; no new request accepted while busy.
//
// Ports:
//   clk, rst_n              - clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready       - request handshake; in_ready high only in IDLE
//   in_data, in_mask        - source word and per-slot enable, captured at accept
//   out_valid/out_ready     - result handshake
//   out_data, out_len       - packed bits (zero above out_len) and their count
//   busy, field_idx         - walking/done indicator, slot currently being walked
module genhier_pack_seq #(
    parameter int NFIELDS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_data,
    input  logic [NFIELDS-1:0] in_mask,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_data,
    output logic [7:0]         out_len,
    output logic               busy,
    output logic [5:0]         field_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NFIELDS - 1);

    state_t             state;
    logic [127:0]       data_q;
    logic [NFIELDS-1:0] mask_q;
    logic [127:0]       acc;
    logic [7:0]         wofs;

    logic [4:0]   pair;
    logic [7:0]   src_lsb;
    logic [3:0]   fld;
    logic [7:0]   fld_w;
    logic         fld_en;
    logic [127:0] acc_next;
    logic [7:0]   ofs_next;

    // Slot geometry from the index: each slot pair spans 7 bits, the odd
    // slot of a pair sits 3 bits above the even one.
    always_comb begin
        pair     = field_idx[5:1];
        src_lsb  = {pair, 3'b000} - {3'b000, pair} + (field_idx[0] ? 8'd3 : 8'd0);
        fld      = 4'(data_q >> src_lsb);
        if (!field_idx[0]) begin
            fld[3] = 1'b0;
        end
        fld_w    = field_idx[0] ? 8'd4 : 8'd3;
        fld_en   = 1'(mask_q >> field_idx);
        acc_next = acc;
        ofs_next = wofs;
        if (fld_en) begin
            acc_next = acc | ({124'd0, fld} << wofs);
            ofs_next = wofs + fld_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            data_q    <= '0;
            mask_q    <= '0;
            acc       <= '0;
            wofs      <= '0;
            field_idx <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        data_q    <= in_data;
                        mask_q    <= in_mask;
                        acc       <= '0;
                        wofs      <= '0;
                        field_idx <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_WALK;
                    end
                end
                S_WALK: begin
                    acc  <= acc_next;
                    wofs <= ofs_next;
                    if (field_idx == LAST_IDX) begin
                        // Result registers load from the final slot's update so
                        // they are valid on the same edge DONE is entered.
                        field_idx <= '0;
                        out_data  <= acc_next;
                        out_len   <= ofs_next;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        field_idx <= field_idx + 6'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    field_idx <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_genhier_pack_seq.sv
module tb_genhier_pack_seq;

    localparam int NF = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  in_data = '0;
    logic [NF-1:0] in_mask = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [127:0]  out_data;
    logic [7:0]    out_len;
    logic          busy;
    logic [5:0]    field_idx;

    int checks = 0;
    int failures = 0;

    genhier_pack_seq #(.NFIELDS(NF)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_len(out_len),
        .busy(busy), .field_idx(field_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: walk slots in order, copying enabled fields bit by bit.
    function automatic void model(input logic [127:0] d, input logic [NF-1:0] m,
                                  output logic [127:0] res, output int len);
        res = '0;
        len = 0;
        for (int i = 0; i < NF; i++) begin
            int lsb = (i / 2) * 7 + (i % 2) * 3;
            int w   = 3 + (i % 2);
            if (m[i]) begin
                for (int b = 0; b < w; b++) begin
                    res[len] = d[lsb + b];
                    len++;
                end
            end
        end
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Issue one request, check latency/index sequence, result, hold and release.
    // hold: cycles of out_ready=0 in DONE; pre_rdy: out_ready already high during the walk.
    task automatic run_req(input string tag, input logic [127:0] d, input logic [NF-1:0] m,
                           input int hold, input bit pre_rdy);
        logic [127:0] exp_d;
        int exp_l;
        model(d, m, exp_d, exp_l);
        @(negedge clk);
        chk({tag, ":in_ready_idle"}, 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = m;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_data   = rnd128();
        in_mask   = NF'($urandom());
        out_ready = pre_rdy;
        for (int c = 0; c < NF; c++) begin
            if (c == 0 || c == NF - 1) begin
                chk($sformatf("%s:idx%0d", tag, c), 128'(field_idx), 128'(c));
                chk($sformatf("%s:nov%0d", tag, c), 128'({out_valid, busy, in_ready}), 128'(3'b010));
            end else begin
                checks++;
                assert (field_idx === 6'(c) && out_valid === 1'b0) else begin
                    failures++;
                    $error("FAIL %s:walk%0d observed idx=%0d ov=%b expected idx=%0d ov=0",
                           tag, c, field_idx, out_valid, c);
                end
            end
            @(posedge clk); #1;
        end
        chk({tag, ":out_valid"}, 128'(out_valid), 128'(1));
        chk({tag, ":out_data"}, out_data, exp_d);
        chk({tag, ":out_len"}, 128'(out_len), 128'(exp_l));
        if (!pre_rdy) begin
            for (int h = 0; h < hold; h++) begin
                in_valid = 1'b1;
                in_data  = rnd128();
                @(posedge clk); #1;
                checks++;
                assert (out_valid === 1'b1 && in_ready === 1'b0 && out_data === exp_d &&
                        out_len === 8'(exp_l)) else begin
                    failures++;
                    $error("FAIL %s:hold%0d observed ov=%b ir=%b len=%0d expected ov=1 ir=0 len=%0d",
                           tag, h, out_valid, in_ready, out_len, exp_l);
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, ":release"}, 128'({out_valid, busy, in_ready}), 128'(3'b001));
        chk({tag, ":held_len"}, 128'(out_len), 128'(exp_l));
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] d;
        #12;
        chk("reset_outs", {out_data[119:0], out_len}, 128'd0);
        chk("reset_ctl", 128'({in_ready, out_valid, busy, field_idx}), 128'(9'b1_0_0_000000));
        @(negedge clk);
        rst_n = 1'b1;

        run_req("basic", 128'h65, 8'h03, 0, 1'b0);
        chk("basic_const", out_data, 128'h65);
        chk("basic_len", 128'(out_len), 128'd7);

        run_req("full1", '1, 8'hFF, 0, 1'b0);
        chk("full1_const", out_data, 128'hFFF_FFFF);
        run_req("full0f", 128'h0F0F_0F0F, 8'hFF, 0, 1'b0);

        d = 128'(4'hC) << 3;
        d = d | (128'(4'h9) << 24);
        run_req("sparse", d, 8'b1000_0010, 0, 1'b0);
        chk("sparse_const", out_data, 128'h9C);
        chk("sparse_len", 128'(out_len), 128'd8);

        run_req("empty", rnd128(), 8'h00, 0, 1'b0);
        chk("empty_len", 128'(out_len), 128'd0);

        run_req("bp", rnd128(), 8'hA5, 5, 1'b0);
        run_req("after_bp", rnd128(), 8'h5A, 0, 1'b0);
        run_req("prerdy", rnd128(), 8'h3C, 0, 1'b1);

        // Reset in the middle of a walk.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = '1;
        in_mask  = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
        end
        chk("mid_idx", 128'(field_idx), 128'd4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst", 128'({in_ready, out_valid, busy, field_idx}), 128'(9'b1_0_0_000000));
        @(negedge clk);
        rst_n = 1'b1;
        run_req("post_rst", 128'h0, 8'hFF, 0, 1'b0);
        chk("post_rst_zero", out_data, 128'd0);

        for (int r = 0; r < 10; r++) begin
            run_req($sformatf("rnd%0d", r), rnd128(), NF'($urandom()),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/genhier_pack_seq.md
# genhier_pack_seq

Sequential field-packing controller for the alternating 3-bit/4-bit slot datapath used by the generate-hierarchy cosims. The block accepts a 128-bit word and a per-field enable mask, then walks the field slots one per cycle. Even slots are 3 bits and odd slots are 4 bits, on a 7-bit stride per slot pair. Each enabled field is appended, LSB-first, to a densely packed result, which is returned with its bit length over a valid/ready handshake.

## Interface
- `NFIELDS`, default 8: number of field slots. Must be even, range 2..36.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: request carries a word to pack.
- `in_ready` out 1: block can accept a request; high only in IDLE.
- `in_data` in 128: source word.
- `in_mask` in NFIELDS: bit i=1 means field i is packed; bit i=0 means field i is skipped.
- `out_valid` out 1: packed result available.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 128: packed fields, LSB-aligned; all bits at and above `out_len` are 0.
- `out_len` out 8: number of valid packed bits, 0..(NFIELDS/2)*7.
- `busy` out 1: high in WALK or DONE.
- `field_idx` out 6: index of the slot being processed in WALK; 0 otherwise.

## Operation
- **Field geometry.**
  - Slot i even: width 3, LSB at (i>>1)*7.
  - Slot i odd: width 4, LSB at (i>>1)*7+3.
  - Offsets are computed from `field_idx`. No lookup table is required for correctness.
- **FSM states: IDLE, WALK, DONE.**
  - IDLE: `in_ready`=1. On `in_valid`&`in_ready`:
    - capture `in_data` and `in_mask`;
    - clear the accumulator, write offset and `field_idx` to 0;
    - go to WALK.
  - WALK: one slot per cycle.
    - If `mask[field_idx]`=1, write the field into the accumulator at the write offset, then write offset += field width (3 or 4).
    - If `mask[field_idx]`=0, the accumulator and offset are unchanged.
    - `field_idx` increments each cycle. After slot NFIELDS-1 is processed, go to DONE.
  - DONE: `out_valid`=1. `out_data` = accumulator, `out_len` = write offset. On `out_ready`, go to IDLE.
- Every slot costs one cycle whether enabled or not, so latency is data-independent.
- The write offset never exceeds (NFIELDS/2)*7. The accumulator is never written above that bit.
- `in_data` and `in_mask` are ignored outside the IDLE handshake. The captured copy is used throughout the walk.
- A new request is never accepted while `busy`=1. There is no same-cycle DONE→accept.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `out_data`=0, `out_len`=0, `busy`=0, `field_idx`=0. State is IDLE.
- **Assertion of `rst_n`=0 in any state:**
  - all outputs go to their reset values immediately (asynchronously);
  - any in-flight word is discarded, with no partial output.
- **Latency:** if a request is accepted at edge T, `out_valid` rises after edge T+NFIELDS (WALK occupies edges T+1..T+NFIELDS).
- **Result stability:** `out_valid`, `out_data` and `out_len` are registered and remain stable while `out_valid`=1 and `out_ready`=0.
- **Release:** result accepted at edge R, then `out_valid`=0 and `in_ready`=1 after R. The earliest next accept is edge R+1.
- **Throughput:** minimum request-to-request period is NFIELDS+2 cycles.
- **Boundary cases:**
  - `out_ready` held high before `out_valid`: DONE lasts exactly one cycle.
  - All-zero mask: `out_len`=0 and `out_data`=0, delivered at the normal latency.
- **Outputs outside DONE:** `out_data` and `out_len` hold their last value after release. They are only meaningful when `out_valid`=1.

## Test plan
- **Basic pack:** NFIELDS=8, mask=8'h03, `in_data[6:0]`=7'b1100_101. Expect `out_data`=128'h65, `out_len`=8'd7, with `out_valid` arriving 8 cycles after the accept edge.
- **Full mask:** mask=8'hFF, `in_data`=all ones. Expect `out_data`=28'hFFFFFFF (upper bits 0) and `out_len`=28. Then repeat with `in_data`=128'h0F0F_0F0F and check against a reference model.
- **Sparse mask:** mask=8'b1000_0010 with field1=4'hC and field7=4'h9. Expect `out_data`=8'h9C, `out_len`=8, and no gaps left by the skipped slots.
- **Empty mask:** mask=0 with arbitrary `in_data`. Expect `out_len`=0, `out_data`=0, latency still 8 cycles, and `field_idx` counting 0..7.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE.
  - Expect `out_data`/`out_len` stable and `in_ready`=0 throughout, with `in_valid` ignored.
  - After `out_ready`=1, expect `in_ready`=1 next cycle; a second word then completes correctly.
- **Reset mid-walk:** drop `rst_n` when `field_idx`=4.
  - Expect immediate return to IDLE with `out_valid`=0 and `busy`=0.
  - After release, a new request packs correctly with no stale bits from the aborted word.
